// File: rtl/mock8080_pkg.sv
// Shared definitions for the Mock8080 memory/loader slice: loader FSM encoding,
// frame defaults and RAM geometry.
package mock8080_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int MEM_AW    = 8;
    localparam int MEM_DW    = 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_RST_TICKS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RELEASE
    } ld_state_e;

    // Frame length byte 0 stands for a full 256-byte page.
    function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'(MEM_DEPTH) : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/module_memory_loader_if.sv
// Bundle of the CPU memory bus, host byte stream and CPU control lines
// between the Mock8080 side (master) and the memory/loader block (slave).
interface module_memory_loader_if;
    import mock8080_pkg::*;

    logic [MEM_AW-1:0] cpu_addr;
    logic [MEM_DW-1:0] cpu_wdata;
    logic              cpu_we;
    logic [MEM_DW-1:0] cpu_rdata;
    logic [7:0]        ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic              step_tick;
    logic              cpu_en;
    logic              cpu_reset;
    logic [MEM_AW-1:0] cpu_res_addr;
    logic              ld_busy;
    logic              ld_err;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, ld_data, ld_valid, step_tick,
        output cpu_rdata, ld_ready, cpu_en, cpu_reset, cpu_res_addr, ld_busy, ld_err
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, ld_data, ld_valid, step_tick,
        input  cpu_rdata, ld_ready, cpu_en, cpu_reset, cpu_res_addr, ld_busy, ld_err
    );

endinterface

// File: rtl/mem_ram_256x8.sv
// Single-clock 256x8 RAM: one write port, one registered read port with
// read-old-data behaviour on a same-address collision. Contents are never reset.
module mem_ram_256x8
    import mock8080_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  logic [MEM_DW-1:0] wdata_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output logic [MEM_DW-1:0] rdata_o
);

    logic [MEM_DW-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/module_memory_loader.sv
// Mock8080 program RAM plus host frame loader that fills it and restarts the CPU.
// Define MEM_LOADER_CHECKSUM_EN to add the trailing checksum byte and ld_err reporting.
module module_memory_loader
    import mock8080_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         RST_TICKS = DEFAULT_RST_TICKS
)
(
    input  logic                   clk_qzt,
    input  logic                   reset_n,
    module_memory_loader_if.slave  bus
);

    localparam logic [7:0] TICK_LAST = 8'(RST_TICKS - 1);

    ld_state_e         state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] res_addr_q, res_addr_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic [7:0]        tick_q, tick_d;
    logic              rd_valid_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
    logic [7:0]        csum_total;
`endif

    logic              ld_ready;
    logic              accept;
    logic              ld_we;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_waddr;
    logic [MEM_DW-1:0] ram_wdata;
    logic [MEM_DW-1:0] ram_rdata;

    assign ld_ready = (state_q != ST_RELEASE);
    assign accept   = bus.ld_valid && ld_ready;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign csum_total = sum_q + bus.ld_data;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        res_addr_d  = res_addr_q;
        cpu_en_d    = cpu_en_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        tick_d      = tick_q;
        ld_we       = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.ld_data == SYNC_BYTE)) begin
                    state_d  = ST_ADDR;
                    cpu_en_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    err_d    = 1'b0;
`endif
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    ptr_d      = bus.ld_data;
                    res_addr_d = bus.ld_data;
                    state_d    = ST_LEN;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d      = bus.ld_data;
`endif
                end
            end
            ST_LEN: begin
                if (accept) begin
                    cnt_d   = decode_len(bus.ld_data);
                    state_d = ST_DATA;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d   = csum_total;
`endif
                end
            end
            ST_DATA: begin
                if (accept) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + 8'd1;
                    cnt_d = cnt_q - 9'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = csum_total;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_CSUM;
                    end
`else
                    if (cnt_q == 9'd1) begin
                        state_d     = ST_RELEASE;
                        cpu_en_d    = 1'b1;
                        cpu_reset_d = 1'b1;
                        tick_d      = 8'd0;
                    end
`endif
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (csum_total == 8'h00) begin
                        state_d     = ST_RELEASE;
                        cpu_en_d    = 1'b1;
                        cpu_reset_d = 1'b1;
                        tick_d      = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            ST_RELEASE: begin
                // The tick sampled on the entry edge was seen while still in DATA/CSUM.
                if (bus.step_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d     = ST_IDLE;
                        cpu_reset_d = 1'b0;
                        busy_d      = 1'b0;
                        tick_d      = 8'd0;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            res_addr_q  <= '0;
            cpu_en_q    <= 1'b0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= '0;
            rd_valid_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            res_addr_q  <= res_addr_d;
            cpu_en_q    <= cpu_en_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            tick_q      <= tick_d;
            rd_valid_q  <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    // Loader owns the write port whenever it writes; a colliding CPU write is dropped.
    assign ram_we    = ld_we | bus.cpu_we;
    assign ram_waddr = ld_we ? ptr_q : bus.cpu_addr;
    assign ram_wdata = ld_we ? bus.ld_data : bus.cpu_wdata;

    mem_ram_256x8 u_ram (
        .clk_i   (clk_qzt),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (bus.cpu_addr),
        .rdata_o (ram_rdata)
    );

    // RAM has no reset, so the read path is masked until the first post-reset edge.
    assign bus.cpu_rdata    = rd_valid_q ? ram_rdata : '0;
    assign bus.ld_ready     = ld_ready;
    assign bus.cpu_en       = cpu_en_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.cpu_res_addr = res_addr_q;
    assign bus.ld_busy      = busy_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign bus.ld_err       = err_q;
`else
    assign bus.ld_err       = 1'b0;
`endif

endmodule

// File: tb/tb_module_memory_loader.sv
// Directed self-checking bench for module_memory_loader (frames, wrap, N=0,
// CPU port collisions, mid-frame reset, checksum build when enabled).
module tb_module_memory_loader;

    logic clk_qzt = 1'b0;
    logic reset_n;

    always #5 clk_qzt = ~clk_qzt;

    module_memory_loader_if bus ();

    module_memory_loader #(
        .SYNC_BYTE (8'hA5),
        .RST_TICKS (2)
    ) dut (
        .clk_qzt (clk_qzt),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] run_sum;
    logic [7:0] rd;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit tk, input bit clash);
        bus.ld_data   = b;
        bus.ld_valid  = 1'b1;
        bus.step_tick = tk;
        bus.cpu_we    = clash;
        @(posedge clk_qzt); #1;
        bus.ld_valid  = 1'b0;
        bus.step_tick = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] s, input logic [7:0] n);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(s, 1'b0, 1'b0);
        send_byte(n, 1'b0, 1'b0);
        run_sum = s + n;
        $display("[TB] frame start S=%02h N=%02h", s, n);
    endtask

    // Last data byte (or trailing checksum) carries a step_tick that must be ignored.
    task automatic send_data(input logic [7:0] b, input bit last, input bit clash);
        run_sum = run_sum + b;
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(b, 1'b0, clash);
        if (last) send_byte(~run_sum + 8'd1, 1'b1, 1'b0);
`else
        send_byte(b, last, clash);
`endif
    endtask

    task automatic pulse_tick();
        bus.step_tick = 1'b1;
        @(posedge clk_qzt); #1;
        bus.step_tick = 1'b0;
    endtask

    task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
        bus.cpu_addr = a;
        @(posedge clk_qzt); #1;
        d = bus.cpu_rdata;
        $display("[TB] read  mem[%02h] = %02h", a, d);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        @(posedge clk_qzt); #1;
        bus.cpu_we    = 1'b0;
        $display("[TB] write mem[%02h] <= %02h", a, d);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.ld_data   = 8'h00;
        bus.ld_valid  = 1'b0;
        bus.step_tick = 1'b0;
        run_sum       = 8'h00;
        repeat (3) @(posedge clk_qzt);
        #1;
        check_val("rst_rdata",    16'(bus.cpu_rdata),    16'h00);
        check_val("rst_ready",    16'(bus.ld_ready),     16'h1);
        check_val("rst_en",       16'(bus.cpu_en),       16'h0);
        check_val("rst_cpureset", 16'(bus.cpu_reset),    16'h0);
        check_val("rst_resaddr",  16'(bus.cpu_res_addr), 16'h00);
        check_val("rst_busy",     16'(bus.ld_busy),      16'h0);
        check_val("rst_err",      16'(bus.ld_err),       16'h0);
        reset_n = 1'b1;

        // Frame A: noise bytes first, then a 3-byte frame at 0x10.
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        check_val("noise_busy", 16'(bus.ld_busy), 16'h0);
        send_byte(8'hA5, 1'b0, 1'b0);
        check_val("sync_busy", 16'(bus.ld_busy), 16'h1);
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        run_sum = 8'h13;
        send_data(8'hAA, 1'b0, 1'b0);
        send_data(8'hBB, 1'b0, 1'b0);
        send_data(8'hCC, 1'b1, 1'b0);
        check_val("a_rel_en",      16'(bus.cpu_en),       16'h1);
        check_val("a_rel_reset",   16'(bus.cpu_reset),    16'h1);
        check_val("a_rel_ready",   16'(bus.ld_ready),     16'h0);
        check_val("a_rel_resaddr", 16'(bus.cpu_res_addr), 16'h10);
        pulse_tick();
        check_val("a_tick1_reset", 16'(bus.cpu_reset), 16'h1);
        pulse_tick();
        check_val("a_tick2_reset", 16'(bus.cpu_reset), 16'h0);
        check_val("a_tick2_busy",  16'(bus.ld_busy),   16'h0);
        check_val("a_tick2_ready", 16'(bus.ld_ready),  16'h1);
        check_val("a_tick2_en",    16'(bus.cpu_en),    16'h1);
        read_mem(8'h10, rd); check_val("a_mem10", 16'(rd), 16'hAA);
        read_mem(8'h11, rd); check_val("a_mem11", 16'(rd), 16'hBB);
        read_mem(8'h12, rd); check_val("a_mem12", 16'(rd), 16'hCC);

        // Address wrap FE -> FF -> 00.
        send_hdr(8'hFE, 8'h03);
        check_val("wrap_en_low", 16'(bus.cpu_en), 16'h0);
        send_data(8'h01, 1'b0, 1'b0);
        send_data(8'h02, 1'b0, 1'b0);
        send_data(8'h03, 1'b1, 1'b0);
        pulse_tick();
        pulse_tick();
        check_val("wrap_resaddr", 16'(bus.cpu_res_addr), 16'hFE);
        read_mem(8'hFE, rd); check_val("wrap_memFE", 16'(rd), 16'h01);
        read_mem(8'hFF, rd); check_val("wrap_memFF", 16'(rd), 16'h02);
        read_mem(8'h00, rd); check_val("wrap_mem00", 16'(rd), 16'h03);

        // N=0 encodes 256 bytes; data byte k is k^C3.
        send_hdr(8'h40, 8'h00);
        for (int k = 0; k < 255; k++) send_data(8'(k) ^ 8'hC3, 1'b0, 1'b0);
        check_val("n0_ready_255", 16'(bus.ld_ready),  16'h1);
        check_val("n0_reset_255", 16'(bus.cpu_reset), 16'h0);
        send_data(8'hFF ^ 8'hC3, 1'b1, 1'b0);
        check_val("n0_reset_256", 16'(bus.cpu_reset), 16'h1);
        pulse_tick();
        pulse_tick();
        read_mem(8'h40, rd); check_val("n0_mem40", 16'(rd), 16'hC3);
        read_mem(8'h3F, rd); check_val("n0_mem3F", 16'(rd), 16'h3C);

        // CPU port: write/read-back and read-during-write returns old data.
        cpu_write(8'h20, 8'h5A);
        read_mem(8'h20, rd); check_val("cpu_rd20", 16'(rd), 16'h5A);
        cpu_write(8'h20, 8'h66);
        check_val("cpu_rdw_old", 16'(bus.cpu_rdata), 16'h5A);
        read_mem(8'h20, rd); check_val("cpu_rd20_new", 16'(rd), 16'h66);

        // Loader and CPU write to 0x20 on the same edge: loader wins.
        send_hdr(8'h20, 8'h01);
        bus.cpu_addr  = 8'h20;
        bus.cpu_wdata = 8'h11;
        send_data(8'h77, 1'b1, 1'b1);
        pulse_tick();
        pulse_tick();
        read_mem(8'h20, rd); check_val("clash_mem20", 16'(rd), 16'h77);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Bad checksum: 30+01+55 = 86, so 00 is wrong.
        send_hdr(8'h30, 8'h01);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        check_val("cs_bad_err",   16'(bus.ld_err),  16'h1);
        check_val("cs_bad_en",    16'(bus.cpu_en),  16'h0);
        check_val("cs_bad_busy",  16'(bus.ld_busy), 16'h0);
        check_val("cs_bad_reset", 16'(bus.cpu_reset), 16'h0);
        send_hdr(8'h31, 8'h01);
        check_val("cs_good_errclr", 16'(bus.ld_err), 16'h0);
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h68, 1'b0, 1'b0);
        check_val("cs_good_en",    16'(bus.cpu_en),    16'h1);
        check_val("cs_good_reset", 16'(bus.cpu_reset), 16'h1);
        pulse_tick();
        pulse_tick();
`endif

        // Reset in the middle of DATA.
        send_hdr(8'h80, 8'h04);
        send_data(8'h91, 1'b0, 1'b0);
        send_data(8'h92, 1'b0, 1'b0);
        check_val("mid_busy_pre", 16'(bus.ld_busy), 16'h1);
        reset_n = 1'b0;
        #1;
        check_val("mid_busy_rst", 16'(bus.ld_busy), 16'h0);
        check_val("mid_en_rst",   16'(bus.cpu_en),  16'h0);
        @(posedge clk_qzt); #1;
        reset_n = 1'b1;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        send_byte(8'h93, 1'b0, 1'b0);
        check_val("mid_noise_busy", 16'(bus.ld_busy), 16'h0);
        check_val("mid_noise_en",   16'(bus.cpu_en),  16'h0);
        read_mem(8'h80, rd); check_val("mid_mem80", 16'(rd), 16'h91);
        read_mem(8'h81, rd); check_val("mid_mem81", 16'(rd), 16'h92);
        read_mem(8'h82, rd); check_val("mid_mem82", 16'(rd), 16'h81);

        send_hdr(8'h90, 8'h01);
        send_data(8'h44, 1'b1, 1'b0);
        check_val("post_en",      16'(bus.cpu_en),       16'h1);
        check_val("post_resaddr", 16'(bus.cpu_res_addr), 16'h90);
        pulse_tick();
        pulse_tick();
        read_mem(8'h90, rd); check_val("post_mem90", 16'(rd), 16'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/module_memory_loader.md
# module_memory_loader

256×8 program/data RAM that serves the Mock8080 CPU's memory bus, plus a byte-stream loader that fills the RAM from a host link and then restarts the CPU at the loaded start address. It sits directly downstream of the CPU's `data_addr`/`data_out`/`write_en` outputs and drives the CPU's `data_in`, `en`, `reset` and `res_addr` inputs.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame-start marker.
- `RST_TICKS`, default 2: number of `step_tick` pulses `cpu_reset` is held.
- `clk_qzt`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cpu_addr`  in  8: CPU `data_addr`.
- `cpu_wdata`  in  8: CPU `data_out`.
- `cpu_we`  in  1: CPU `write_en`.
- `cpu_rdata`  out  8: to CPU `data_in`; registered read data.
- `ld_data`  in  8: host byte.
- `ld_valid`  in  1: host byte valid.
- `ld_ready`  out  1: loader can accept a byte.
- `step_tick`  in  1: one-cycle pulse per CPU slave-clock step.
- `cpu_en`  out  1: CPU enable.
- `cpu_reset`  out  1: CPU reset request.
- `cpu_res_addr`  out  8: CPU restart address.
- `ld_busy`  out  1: frame in progress.
- `ld_err`  out  1: last frame rejected (checksum build only).

## Operation
- Frame: `SYNC_BYTE`, start address S, length N (0 encodes 256), N data bytes, [checksum byte].
- Byte accepted on a clock edge where `ld_valid && ld_ready`.
- FSM states: IDLE → ADDR → LEN → DATA → (CSUM) → RELEASE → IDLE.
  - IDLE: non-sync bytes are consumed and discarded; sync byte → ADDR, `cpu_en`←0, `ld_busy`←1, `ld_err`←0.
  - ADDR: latch S into write pointer and `cpu_res_addr`.
  - LEN: latch N into 9-bit remaining counter (0 → 256).
  - DATA: each byte writes `mem[ptr]`, ptr←ptr+1 mod 256 (wraps 8'hFF→8'h00), counter−1; at counter 1 → CSUM or RELEASE.
  - RELEASE: `ld_ready`=0, `cpu_en`=1, `cpu_reset`=1; count `step_tick` pulses; after `RST_TICKS` → IDLE, `cpu_reset`←0, `ld_busy`←0.
- CPU port: `cpu_rdata` ← `mem[cpu_addr]` every cycle. If `cpu_we` is high, `mem[cpu_addr]` ← `cpu_wdata`.
- Simultaneous loader and CPU write: loader wins; CPU write dropped. CPU is disabled during DATA, so this occurs only on a protocol fault.
- `ld_ready` is 1 in IDLE/ADDR/LEN/DATA/CSUM and 0 in RELEASE.

## Timing
- Reset values: `cpu_rdata`=0, `ld_ready`=1 (IDLE), `cpu_en`=0, `cpu_reset`=0, `cpu_res_addr`=0, `ld_busy`=0, `ld_err`=0, FSM=IDLE, step counter 0.
- RAM contents are not reset and are preserved across `reset_n`.
- Read latency is 1 `clk_qzt` cycle. Read during write to the same address returns the old data.
- A loader write is visible on `cpu_rdata` 2 cycles after acceptance when addressed.
- Throughput is one byte per cycle; `ld_ready` never drops mid-frame.
- `cpu_en` falls on the cycle after sync acceptance. `cpu_en` and `cpu_reset` rise together on entry to RELEASE.
- `step_tick` coincident with RELEASE entry is not counted.
- `reset_n` mid-frame: FSM→IDLE, bytes already written remain, `cpu_en`=0 until the next complete frame.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state present.
  - Running 8-bit sum of S, N byte and data bytes, mod 256. The frame is valid when (sum + checksum byte) mod 256 == 0.
  - On mismatch: `ld_err`←1, → IDLE without release; `cpu_en` stays 0.
- Undefined: no CSUM state, DATA → RELEASE directly, `ld_err` tied 0.

## Structure
- Shared package `mock8080_pkg`: FSM state encoding, default `SYNC_BYTE`, memory depth/width constants.
- One sub-module `mem_ram_256x8`: single-clock RAM, one write port, one registered read port, no reset. The write mux (loader vs CPU) lives in the parent.

## Test plan
- Frame A5,10,03,AA,BB,CC then 2 `step_tick` → mem[10..12]=AA,BB,CC; `cpu_res_addr`=10; `cpu_reset` high exactly until 2nd tick; `cpu_en`=1.
- S=FE, N=3, data 01,02,03 → mem[FE]=01, mem[FF]=02, mem[00]=03 (wrap).
- N=0 → 256 bytes accepted before RELEASE; byte 256 lands at S−1.
- CPU write 5A to 20 then read 20 → `cpu_rdata`=5A one cycle after address presented; simultaneous loader write to 20 with 77 → 77 wins.
- Checksum build: correct checksum → release; wrong checksum → `ld_err`=1, `cpu_en`=0, next good frame clears `ld_err`.
- `reset_n` low mid-DATA → `ld_busy`=0, `cpu_en`=0, written bytes kept; bytes 00/FF before sync ignored.
